serial_detect_sched: RTL and testbench
======================================

Name: serial_detect_sched

Overview:
- Round-robin scheduler that shares one serial sequence-detector instance among N requesters.
- Each requester presents a W-bit parallel word. The scheduler grants one requester, clears the detector, and shifts the word into the detector's serial input x MSB-first, one bit per clk.
- It counts detector z pulses and returns the hit count, tagged with the requester id.
- Sits between the parallel-word sources and the serial detector.

Parameters:
- N, 4, number of requesters (2..8).
- W, 25, bits per job word.
- DET_LAT, 1, detector x-to-z latency in cycles; drain cycles appended after the last bit.
- CW, 8, hit-counter width; the counter saturates at 2^CW-1.

Ports:
- clk, in, 1, single clock, all state on rising edge.
- rst, in, 1, asynchronous, active-high reset.
- req, in, N, per-requester job request; level held until granted.
- data_in, in, N*W, requester i word at bits [i*W +: W].
- gnt, out, N, one-hot, 1-cycle pulse when requester's word is latched.
- x, out, 1, serial bit to detector.
- det_clr, out, 1, 1-cycle detector clear pulse, active-high.
- z, in, 1, detector hit flag, sampled every cycle.
- busy, out, 1, high in every state except IDLE.
- done, out, 1, 1-cycle pulse, job result valid.
- done_id, out, $clog2(N), id of finished job; held until next done.
- hit_cnt, out, CW, z count of finished job; held until next done.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; rr_ptr=0.
  - gnt=0, x=0, det_clr=0, busy=0, done=0, done_id=0, hit_cnt=0.
  - Shift register and counters are cleared.
  - Reset asserted mid-job abandons the job silently: no done, no gnt.
- States: IDLE -> LOAD -> CLEAR -> SHIFT -> DRAIN -> DONE -> IDLE.
- IDLE:
  - If |req, select a winner by round-robin: the first set req at or after rr_ptr, wrapping modulo N.
  - Latch win_id and data_in[win_id] into the shift register, then go to LOAD.
  - If no req, stay in IDLE.
- LOAD (1 cycle): gnt[win_id]=1. The requester may drop req from the next cycle on.
- CLEAR (1 cycle):
  - det_clr=1, x=0.
  - Hit counter and bit counter are cleared.
- SHIFT (exactly W cycles):
  - x = sreg[W-1]; sreg shifts left each cycle.
  - Cycle k (0-based) carries word bit W-1-k.
- DRAIN (DET_LAT cycles): x=0. DET_LAT=0 skips DRAIN.
- Hit counting:
  - z is counted (+1 per cycle with z=1) only in SHIFT and DRAIN cycles.
  - z in IDLE, LOAD, CLEAR or DONE is ignored.
  - The counter saturates at 2^CW-1.
- DONE (1 cycle):
  - done=1; done_id=win_id and hit_cnt=final count are registered on entry and held afterwards.
  - rr_ptr = (win_id+1) mod N.
  - Return to IDLE.
- Job timing: from the req-accept edge to done is 4 + W + DET_LAT cycles. No back-to-back overlap; the next job's IDLE decision happens the cycle after DONE.
- Boundary cases:
  - A req dropped before grant is simply not selected.
  - data_in changes after the IDLE latch edge do not affect the job.
  - With all req high, grants rotate 0,1,...,N-1,0.
  - A single requester with req held continuously is re-granted every job.
  - When rr_ptr points to an idle requester, selection searches onward and wraps.

Decomposition:
- Shared package contains:
  - state encoding constants: IDLE, LOAD, CLEAR, SHIFT, DRAIN, DONE (3-bit).
  - the ID_W = $clog2(N) helper.
- One natural sub-module: rr_arbiter (N-bit req, rr_ptr -> one-hot win and win_id, combinational). It is reusable by other shared-resource blocks.
- Shift register and counters stay in the top FSM.

Test Plan:
1. Reset mid-SHIFT:
   - Stimulus: req=0001, data=25'h0AB5C56; assert rst at cycle 10.
   - Required: all outputs 0 while rst is high; no done; the next job starts cleanly after release.
2. Single job, serial order:
   - Stimulus: req[2]=1, data word 25'b0010_1011_0101_1100_0101_01100, bench holds z=0.
   - Required: gnt=0100 for one cycle, then det_clr one cycle, then x replays the word MSB-first over 25 cycles.
   - Required: done at cycle 4+25+1=30 after accept, done_id=2, hit_cnt=0.
3. Hit counting and window:
   - Stimulus: bench pulses z for 1 cycle at SHIFT cycles 5, 12, 24, at the DRAIN cycle, and during CLEAR.
   - Required: hit_cnt=4 (the CLEAR pulse is ignored).
4. Round-robin fairness:
   - Stimulus: req=1111 held.
   - Required: done_id sequence 0,1,2,3,0 across five jobs; gnt always one-hot.
5. Skip idle requester:
   - Stimulus: rr_ptr=1 after a job by requester 0; req=1001.
   - Required: next grant goes to 3, then 0.
6. Saturation:
   - Stimulus: CW=4, z held high for the whole job, W=25.
   - Required: hit_cnt=15, not wrapped.

Source files
------------

// File: rtl/serial_detect_sched_pkg.sv
// Shared definitions for the serial detector scheduler: FSM state encoding
// and the requester-id width helper.
package serial_detect_sched_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CLEAR = 3'd2,
    SHIFT = 3'd3,
    DRAIN = 3'd4,
    DONE  = 3'd5
  } state_t;

  // Id width for n requesters; never narrower than one bit.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_detect_sched_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first set request at or after
// rr_ptr, wrapping modulo N. Reusable by any shared-resource front end.
module rr_arbiter
  import serial_detect_sched_pkg::*;
#(
  parameter int N    = 4,
  parameter int ID_W = id_w(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] rr_ptr,
  output logic [N-1:0]    win,
  output logic [ID_W-1:0] win_id,
  output logic            any
);

  always_comb begin
    int idx;
    logic found;
    win    = '0;
    win_id = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(rr_ptr) + k) % N;
      if (!found && req[idx]) begin
        found       = 1'b1;
        win_id      = ID_W'(idx);
        win[idx]    = 1'b1;
      end
    end
    any = found;
  end

endmodule

// File: rtl/serial_detect_sched.sv
// Shares one serial sequence detector among N requesters: grants round-robin,
// clears the detector, shifts the word MSB-first and returns the z hit count.
module serial_detect_sched
  import serial_detect_sched_pkg::*;
#(
  parameter int N       = 4,
  parameter int W       = 25,
  parameter int DET_LAT = 1,
  parameter int CW      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0]          req,
  input  logic [N*W-1:0]        data_in,
  output logic [N-1:0]          gnt,
  output logic                  x,
  output logic                  det_clr,
  input  logic                  z,
  output logic                  busy,
  output logic                  done,
  output logic [id_w(N)-1:0]    done_id,
  output logic [CW-1:0]         hit_cnt
);

  localparam int ID_W = id_w(N);
  localparam int BCW  = $clog2(W + DET_LAT + 1);

  state_t          state_reg, state_next;
  logic [W-1:0]    sreg_reg;
  logic [ID_W-1:0] win_id_reg;
  logic [ID_W-1:0] rr_ptr_reg;
  logic [BCW-1:0]  bit_cnt_reg;
  logic [CW-1:0]   hit_reg;
  logic [CW-1:0]   hit_next;
  logic [ID_W-1:0] done_id_reg;
  logic [CW-1:0]   hit_cnt_reg;

  logic [N-1:0]    arb_win;
  logic [ID_W-1:0] arb_id;
  logic            arb_any;
  logic [W-1:0]    words [N];

  rr_arbiter #(.N(N), .ID_W(ID_W)) u_arb (
    .req    (req),
    .rr_ptr (rr_ptr_reg),
    .win    (arb_win),
    .win_id (arb_id),
    .any    (arb_any)
  );

  for (genvar gi = 0; gi < N; gi++) begin : g_req
    assign words[gi] = data_in[gi*W +: W];
    assign gnt[gi]   = (state_reg == LOAD) && (win_id_reg == ID_W'(gi));
  end

  // z only contributes while the word or its drain tail is in flight.
  assign hit_next = (z && (hit_reg != {CW{1'b1}})) ? hit_reg + CW'(1) : hit_reg;

  always_comb begin
    state_next = state_reg;
    x          = 1'b0;
    det_clr    = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (arb_any) state_next = LOAD;
      end
      LOAD:  state_next = CLEAR;
      CLEAR: begin
        det_clr    = 1'b1;
        state_next = SHIFT;
      end
      SHIFT: begin
        x = sreg_reg[W-1];
        if (bit_cnt_reg == BCW'(W - 1)) state_next = (DET_LAT == 0) ? DONE : DRAIN;
      end
      DRAIN: if (bit_cnt_reg == BCW'(W + DET_LAT - 1)) state_next = DONE;
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      sreg_reg    <= '0;
      win_id_reg  <= '0;
      rr_ptr_reg  <= '0;
      bit_cnt_reg <= '0;
      hit_reg     <= '0;
      done_id_reg <= '0;
      hit_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: if (arb_any) begin
          win_id_reg <= arb_id;
          sreg_reg   <= words[arb_id];
        end
        CLEAR: begin
          hit_reg     <= '0;
          bit_cnt_reg <= '0;
        end
        SHIFT: begin
          sreg_reg    <= {sreg_reg[W-2:0], 1'b0};
          bit_cnt_reg <= bit_cnt_reg + BCW'(1);
          hit_reg     <= hit_next;
        end
        DRAIN: begin
          bit_cnt_reg <= bit_cnt_reg + BCW'(1);
          hit_reg     <= hit_next;
        end
        DONE: rr_ptr_reg <= (win_id_reg == ID_W'(N - 1)) ? '0 : win_id_reg + ID_W'(1);
        default: ;
      endcase
      // Result includes the z sampled in the final SHIFT/DRAIN cycle.
      if (state_next == DONE && state_reg != DONE) begin
        done_id_reg <= win_id_reg;
        hit_cnt_reg <= hit_next;
      end
    end
  end

  assign done_id = done_id_reg;
  assign hit_cnt = hit_cnt_reg;

endmodule

// File: tb/tb_serial_detect_sched.sv
// Scoreboard bench for serial_detect_sched: directed jobs push expected
// (id, hits) results; monitors pop and compare on every done pulse.
module tb_serial_detect_sched;

  localparam int N       = 4;
  localparam int W       = 25;
  localparam int DET_LAT = 1;
  localparam int CW      = 8;
  localparam int IDW     = 2;
  localparam int JOB_CYC = 4 + W + DET_LAT;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] data_in = '0;
  logic [N-1:0]   gnt;
  logic           x, det_clr, busy, done;
  logic           z = 1'b0;
  logic [IDW-1:0] done_id;
  logic [CW-1:0]  hit_cnt;

  logic [N-1:0]   req_s = '0;
  logic [N*W-1:0] data_s = '0;
  logic [N-1:0]   gnt_s;
  logic           x_s, det_clr_s, busy_s, done_s;
  logic           z_s = 1'b0;
  logic [IDW-1:0] done_id_s;
  logic [3:0]     hit_cnt_s;

  serial_detect_sched #(.N(N), .W(W), .DET_LAT(DET_LAT), .CW(CW)) dut (
    .clk(clk), .rst(rst), .req(req), .data_in(data_in), .gnt(gnt), .x(x),
    .det_clr(det_clr), .z(z), .busy(busy), .done(done), .done_id(done_id),
    .hit_cnt(hit_cnt)
  );

  serial_detect_sched #(.N(N), .W(W), .DET_LAT(DET_LAT), .CW(4)) dut_sat (
    .clk(clk), .rst(rst), .req(req_s), .data_in(data_s), .gnt(gnt_s), .x(x_s),
    .det_clr(det_clr_s), .z(z_s), .busy(busy_s), .done(done_s), .done_id(done_id_s),
    .hit_cnt(hit_cnt_s)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [CW-1:0]  hits;
  } exp_t;

  exp_t       q[$];
  logic [3:0] q_sat[$];
  exp_t       mon_e;
  int         total = 0;
  int         bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, want);
    end else begin
      $display("ok   %s: got %0d", name, act);
    end
  endtask

  // Scoreboard monitors.
  always @(negedge clk) begin
    if (!rst) begin
      if (gnt != '0) check("gnt_onehot", 32'($onehot(gnt)), 1);
      if (done) begin
        if (q.size() == 0) check("unexpected_done", 1, 0);
        else begin
          mon_e = q.pop_front();
          check("done_id", 32'(done_id), 32'(mon_e.id));
          check("hit_cnt", 32'(hit_cnt), 32'(mon_e.hits));
        end
      end
      if (done_s) begin
        if (q_sat.size() == 0) check("unexpected_done_sat", 1, 0);
        else check("hit_cnt_sat", 32'(hit_cnt_s), 32'(q_sat.pop_front()));
      end
    end
  end

  task automatic wait_gnt(output logic [N-1:0] g);
    int n;
    n = 0;
    @(negedge clk);
    while (gnt == '0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    g = gnt;
    if (gnt == '0) check("gnt_timeout", 0, 1);
  endtask

  task automatic push_exp(input int id, input int hits);
    exp_t e;
    e.id   = IDW'(id);
    e.hits = CW'(hits);
    q.push_back(e);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt"},     32'(gnt), 0);
    check({tag, "_x"},       32'(x), 0);
    check({tag, "_det_clr"}, 32'(det_clr), 0);
    check({tag, "_busy"},    32'(busy), 0);
    check({tag, "_done"},    32'(done), 0);
    check({tag, "_done_id"}, 32'(done_id), 0);
    check({tag, "_hit_cnt"}, 32'(hit_cnt), 0);
  endtask

  logic [W-1:0] w0, w1, w2;
  logic [N-1:0] g;
  int           exp_ids [5] = '{0, 1, 2, 3, 0};
  int           n;

  initial begin
    w0 = 25'h0AB5C56;
    w1 = 25'h1555555;
    w2 = 25'b0010101101011100010101100;

    // Reset state, then a job aborted mid-SHIFT by reset.
    repeat (2) @(negedge clk);
    check_reset_outputs("rst_init");
    data_in[0*W +: W] = w0;
    req = 4'b0001;
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("busy_mid_shift", 32'(busy), 1);
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    push_exp(0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_gnt(g);
    check("gnt_after_rst", 32'(g), 32'(4'b0001));

    // rr_ptr is now heading to 1: requester 3 then 0 with req=1001.
    req = 4'b1001;
    push_exp(3, 0);
    push_exp(0, 0);
    wait_gnt(g);
    check("gnt_skip_to_3", 32'(g), 32'(4'b1000));
    wait_gnt(g);
    check("gnt_wrap_to_0", 32'(g), 32'(4'b0001));
    req = 4'b0000;

    // Single job on requester 2: serial order and timing.
    data_in[2*W +: W] = w2;
    req = 4'b0100;
    push_exp(2, 0);
    wait_gnt(g);
    check("gnt_req2", 32'(g), 32'(4'b0100));
    req = 4'b0000;
    data_in[2*W +: W] = ~w2;
    @(negedge clk);
    check("det_clr", 32'(det_clr), 1);
    check("x_in_clear", 32'(x), 0);
    for (int k = 0; k < W; k++) begin
      @(negedge clk);
      check($sformatf("x_bit%0d", W - 1 - k), 32'(x), 32'(w2[W-1-k]));
    end
    @(negedge clk);
    check("x_in_drain", 32'(x), 0);
    check("no_done_in_drain", 32'(done), 0);
    @(negedge clk);
    // Gnt cycle is the second of JOB_CYC; DONE is the last.
    check("done_at_job_end", 32'(done), 1);
    check("job_cycles", 32'(W + DET_LAT + 4), 32'(JOB_CYC));

    // Hit window: CLEAR pulse ignored, SHIFT 5/12/24 and DRAIN counted.
    data_in[1*W +: W] = w1;
    req = 4'b0010;
    push_exp(1, 4);
    wait_gnt(g);
    check("gnt_req1_wrap", 32'(g), 32'(4'b0010));
    req = 4'b0000;
    @(negedge clk);
    z = 1'b1;
    for (int k = 0; k < W; k++) begin
      @(negedge clk);
      z = (k == 5 || k == 12 || k == 24);
    end
    @(negedge clk);
    z = 1'b1;
    @(negedge clk);
    z = 1'b0;
    @(negedge clk);

    // Fresh reset, then all requesters held: grants rotate 0,1,2,3,0.
    rst = 1'b1;
    #1;
    check("rst2_hit_cnt", 32'(hit_cnt), 0);
    check("rst2_done_id", 32'(done_id), 0);
    @(negedge clk);
    rst = 1'b0;
    req = 4'b1111;
    for (int i = 0; i < 5; i++) push_exp(exp_ids[i], 0);
    for (int i = 0; i < 5; i++) begin
      wait_gnt(g);
      check($sformatf("rr_gnt%0d", i), 32'(g), 32'(1 << exp_ids[i]));
    end
    req = 4'b0000;

    // Saturation on the CW=4 instance with z held high.
    data_s[0*W +: W] = w0;
    req_s = 4'b0001;
    z_s   = 1'b1;
    q_sat.push_back(4'd15);
    n = 0;
    @(negedge clk);
    while (gnt_s == '0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (gnt_s == '0) check("gnt_sat_timeout", 0, 1);
    req_s = 4'b0000;

    n = 0;
    while ((q.size() != 0 || q_sat.size() != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0 || q_sat.size() != 0) check("drain_timeout", 32'(q.size() + q_sat.size()), 0);
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
